sram_access_seq: RTL
====================

// Module: sram_access_seq
// PURPOSE
//  Downstream consumer of the serial address shifter and data bus steering.
//  Takes the shifted 21-bit address plus a 3-bit AVR command, then sequences
//  SRAM chip enable, output enable and write enable with programmable strobe widths.
//  Keeps an internal address pointer with optional auto-increment, and latches read data.
//  Sits between the AVR control pins/shift register and the SRAM pins.
// PARAMETERS
//  ADDR_W   21  SRAM address width; matches the shift register output
//  DATA_W   8   SRAM/AVR data width
//  RD_WAIT  2   cycles sram_oe_n is held low (legal range 1..15)
//  WR_WAIT  2   cycles sram_we_n is held low (legal range 1..15)
// PORTS
//  clk           in   1       the clock input (avr_clk in the top-level system)
//  rst           in   1       asynchronous, active-high reset
//  addr_in       in   ADDR_W  parallel address from the shift register
//  cmd           in   3       command code; decoding is listed below
//  cmd_valid     in   1       qualifies cmd for one cycle
//  wr_data       in   DATA_W  AVR write byte; sampled in the accept cycle
//  rd_data       out  DATA_W  last byte read from SRAM
//  busy          out  1       high while an SRAM access is in progress
//  done          out  1       one-cycle pulse when a command completes
//  cmd_ovr       out  1       sticky flag: a command arrived while busy
//  sram_addr     out  ADDR_W  address to SRAM; always equals the pointer
//  sram_dout     out  DATA_W  write data driven onto the SRAM bus
//  sram_doe      out  1       tristate enable for sram_dout (1 = drive)
//  sram_din      in   DATA_W  SRAM bus readback
//  sram_ce_n     out  1       SRAM chip enable, active low
//  sram_oe_n     out  1       SRAM output enable, active low
//  sram_we_n     out  1       SRAM write enable, active low
// BEHAVIOUR
//  Reset values:
//   - ptr = 0, rd_data = 0, sram_dout = 0
//   - busy = 0, done = 0, cmd_ovr = 0, sram_doe = 0
//   - sram_ce_n = 1, sram_oe_n = 1, sram_we_n = 1
//   - state = IDLE
//  Reset taken mid-access: all strobes deassert at once; the access is abandoned.
//  Command codes:
//   - 000 NOP
//   - 001 LOAD: ptr <= addr_in
//   - 010 READ
//   - 011 WRITE
//   - 100 READ_INC
//   - 101 WRITE_INC
//   - 110, 111 are ignored, with no done pulse
//  LOAD: no busy. ptr is updated and done pulses in cycle T+1, where T is the accept cycle.
//   LOAD also clears cmd_ovr.
//  State machine: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
//   - IDLE: cmd_valid is accepted in cycle T. wr_data is captured into sram_dout.
//   - SETUP (T+1): busy=1, ce_n=0. For writes, doe=1.
//   - STROBE: RD_WAIT (read) or WR_WAIT (write) cycles. oe_n=0 (read) or we_n=0 (write).
//     A wait counter counts these cycles.
//     On the last STROBE cycle of a read, rd_data <= sram_din.
//   - HOLD: oe_n=we_n=1; ce_n=0; doe stays 1 for writes (data hold time).
//     done=1 this cycle. The _INC commands increment ptr at the end of HOLD.
//   - Next IDLE: busy=0, ce_n=1, doe=0.
//  Latency: done asserts in cycle T+2+RD_WAIT (or T+2+WR_WAIT).
//   A new command can be accepted in the cycle after done.
//  ptr wraps from 2^ADDR_W-1 to 0, with no flag.
//  cmd_valid while busy: the command is dropped and cmd_ovr is set to 1.
//   If cmd_valid is high in the done cycle (HOLD), it is also dropped and sets cmd_ovr.
//  oe_n and we_n are never low together. Strobes are registered outputs (glitch-free).
// CONFIGURATION
//  SRAM_AUTOINC_EN defined:
//   - 100 and 101 post-increment ptr as described above.
//  SRAM_AUTOINC_EN undefined:
//   - 100 and 101 behave exactly as 010 and 011; ptr changes only on LOAD.
//   - The incrementer logic is removed.
// TESTING
//  1. Assert rst mid-WRITE, while we_n=0.
//     -> we_n, ce_n and the other strobes go to 1 asynchronously; doe=0; ptr=0.
//  2. LOAD with addr_in=0x1ABCD, then WRITE with wr_data=0xA5 (WR_WAIT=2).
//     -> sram_addr=0x1ABCD; we_n low for exactly 2 cycles; doe high T+1..T+4; done at T+4.
//  3. Preload SRAM model with 0x3C at 0x1ABCD, then READ.
//     -> oe_n low for 2 cycles; rd_data=0x3C at T+5; done at T+4; busy high T+1..T+4.
//  4. With SRAM_AUTOINC_EN: LOAD 0x1FFFFF, then WRITE_INC twice.
//     -> writes land at 0x1FFFFF, then 0x000000; ptr ends at 0x000001.
//  5. Issue READ, then cmd_valid=1 with WRITE at T+2.
//     -> the WRITE is ignored and cmd_ovr=1. A following LOAD clears cmd_ovr to 0.
//  6. Without SRAM_AUTOINC_EN: LOAD 0x00010, then READ_INC twice.
//     -> both reads at 0x00010; ptr stays 0x00010.

Source files
------------

// File: rtl/sram_access_seq.sv
// SRAM access sequencer: address pointer, command decode and registered CE/OE/WE strobes.
// Optional macro SRAM_AUTOINC_EN enables post-increment of the pointer for READ_INC/WRITE_INC.
module sram_access_seq #(
  parameter int unsigned ADDR_W  = 21,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              cmd_ovr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_doe,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [2:0] CmdLoad     = 3'b001;
  localparam logic [2:0] CmdRead     = 3'b010;
  localparam logic [2:0] CmdWrite    = 3'b011;
  localparam logic [2:0] CmdReadInc  = 3'b100;
  localparam logic [2:0] CmdWriteInc = 3'b101;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              doe_q, doe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
`ifdef SRAM_AUTOINC_EN
  logic              inc_q, inc_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    ptr_d     = ptr_q;
    rd_data_d = rd_data_q;
    dout_d    = dout_q;
    ovr_d     = ovr_q;
    done_d    = 1'b0;
`ifdef SRAM_AUTOINC_EN
    inc_d     = inc_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd)
            CmdLoad: begin
              ptr_d  = addr_in;
              ovr_d  = 1'b0;
              done_d = 1'b1;
            end
            CmdRead, CmdReadInc: begin
              state_d = StSetup;
              wr_d    = 1'b0;
`ifdef SRAM_AUTOINC_EN
              inc_d   = (cmd == CmdReadInc);
`endif
            end
            CmdWrite, CmdWriteInc: begin
              state_d = StSetup;
              wr_d    = 1'b1;
              dout_d  = wr_data;
`ifdef SRAM_AUTOINC_EN
              inc_d   = (cmd == CmdWriteInc);
`endif
            end
            default: ;
          endcase
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = wr_q ? 4'(WR_WAIT - 1) : 4'(RD_WAIT - 1);
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          if (!wr_q) rd_data_d = sram_din;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        state_d = StIdle;
`ifdef SRAM_AUTOINC_EN
        if (inc_q) ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`endif
      end
      default: state_d = StIdle;
    endcase

    // Any command outside IDLE, including the HOLD/done cycle, is dropped.
    if (cmd_valid && (state_q != StIdle)) ovr_d = 1'b1;

    // Strobes are decoded from the next state so every pin comes straight from a flop.
    busy_d = (state_d != StIdle);
    ce_n_d = (state_d == StIdle);
    doe_d  = (state_d != StIdle) && wr_d;
    oe_n_d = !((state_d == StStrobe) && !wr_d);
    we_n_d = !((state_d == StStrobe) && wr_d);
    if (state_d == StHold) done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      ptr_q     <= '0;
      rd_data_q <= '0;
      dout_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
      doe_q     <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
`ifdef SRAM_AUTOINC_EN
      inc_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      ptr_q     <= ptr_d;
      rd_data_q <= rd_data_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
      doe_q     <= doe_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
`ifdef SRAM_AUTOINC_EN
      inc_q     <= inc_d;
`endif
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ovr   = ovr_q;
  assign sram_addr = ptr_q;
  assign sram_dout = dout_q;
  assign sram_doe  = doe_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;

endmodule
